rsa_input_loader: RTL and testbench
===================================

RSA_INPUT_LOADER -- requirements
Module: rsa_input_loader

Interface
REQ-001 SHALL provide parameter WORD_W, default 32: payload width in bits; must be a multiple of 8 and at least 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is sensitive to its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port rx_valid, input, 1 bit: a byte is offered on rx_data.
REQ-005 SHALL have port rx_data, input, 8 bits: the offered byte.
REQ-006 SHALL have port rx_ready, output, 1 bit: the loader accepts a byte; a byte transfers on a clock edge where rx_valid and rx_ready are both high.
REQ-007 SHALL have port data_type, output, 3 bits: command code for the exponentiation controller (0 NONE, 1 DATA, 2 E, 3 N).
REQ-008 SHALL have port word_out, output, WORD_W bits: the assembled operand.
REQ-009 SHALL have port core_done, input, 1 bit: one-cycle completion pulse from the controller.
REQ-010 SHALL have port frame_error, output, 1 bit: one-cycle error pulse.

Function
REQ-011 Frame format SHALL be: 1 header byte, then WORD_W/8 payload bytes, MSB first; valid headers are 0x01 (DATA), 0x02 (E) and 0x03 (N).
REQ-012 The state machine SHALL have states IDLE, PAYLOAD, CHECK, ISSUE, HOLD and WAIT_DONE.
REQ-013 rx_ready SHALL be high only in IDLE, PAYLOAD and CHECK.
REQ-014 In IDLE, a valid header SHALL latch the type, clear the byte counter and move to PAYLOAD.
REQ-015 In IDLE, an invalid header SHALL be consumed, pulse frame_error for one cycle, and leave the state in IDLE.
REQ-016 PAYLOAD SHALL shift each accepted byte into an internal register; after byte WORD_W/8 it SHALL go to CHECK when REQ-026 is compiled in, else to ISSUE.
REQ-017 On entering ISSUE, word_out SHALL load the shift register; word_out SHALL then hold unchanged until the next ISSUE.
REQ-018 ISSUE SHALL last exactly one cycle, with data_type equal to the latched code; data_type SHALL be 0 in every other state.
REQ-019 After ISSUE, type E or N SHALL go to HOLD for one cycle and then to IDLE, so the controller's update strobe sees a stable word_out.
REQ-020 After ISSUE, type DATA SHALL go to WAIT_DONE and stay there until core_done is high, then go to IDLE on the next edge.
REQ-021 A core_done pulse outside WAIT_DONE SHALL be ignored.
REQ-022 rx_valid low SHALL stall PAYLOAD indefinitely, with no timeout and no change to partial data.
REQ-023 The byte counter SHALL be wide enough for WORD_W/8 and SHALL never wrap within a frame.

Reset
REQ-024 While rst is high, the loader SHALL be in IDLE with rx_ready=1, data_type=0, word_out=0, frame_error=0, counter=0 and shift register=0.
REQ-025 Reset mid-frame or in WAIT_DONE SHALL discard the partial frame and generate no data_type pulse.

Configuration
REQ-026 Macro RSA_LOADER_CHECKSUM_EN SHALL control a trailing checksum byte, accepted in CHECK.
- When defined: the expected checksum is the XOR of the header and all payload bytes.
- On a match, the loader SHALL go to ISSUE.
- On a mismatch, it SHALL pulse frame_error, leave word_out unchanged and return to IDLE.
REQ-027 Without RSA_LOADER_CHECKSUM_EN, CHECK SHALL be unreachable and frames SHALL carry no checksum byte.

Structure
REQ-028 A shared package rsa_pkg SHALL hold the data_type codes (NONE/DATA/E/N), the header byte constants and the state encoding.
REQ-029 No sub-module SHALL be used; the shift register and counter are inline.

Verification (WORD_W=32)
REQ-030 Send 0x02,0x00,0x01,0x00,0x01 -> word_out=0x00010001; data_type=2 for one cycle; rx_ready low for 2 cycles, then high.
REQ-031 Send 0x01,0xDE,0xAD,0xBE,0xEF -> data_type=1 for one cycle; rx_ready stays low until 1 cycle after a core_done injected 20 cycles later.
REQ-032 Send header 0x07 -> frame_error pulse; state stays in IDLE; a following 0x03 frame is accepted normally.
REQ-033 Assert rst after 2 payload bytes of a DATA frame -> all outputs return to reset values; no data_type pulse.
REQ-034 rx_valid gaps of 5 cycles between payload bytes -> same word_out as a gap-free transfer.
REQ-035 With RSA_LOADER_CHECKSUM_EN, send 0x03,0x11,0x22,0x33,0x44 and checksum 0x47 -> ISSUE; with checksum 0x00 -> frame_error and word_out unchanged.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared definitions for the RSA operand loader.
//   data_type_e : command codes handed to the exponentiation controller
//   HDR_*       : frame header byte values
//   state_e     : loader state encoding
//   hdr_to_type : maps a header byte to its command code (DT_NONE if invalid)
package rsa_pkg;

  typedef enum logic [2:0] {
    DT_NONE = 3'd0,
    DT_DATA = 3'd1,
    DT_E    = 3'd2,
    DT_N    = 3'd3
  } data_type_e;

  localparam logic [7:0] HDR_DATA = 8'h01;
  localparam logic [7:0] HDR_E    = 8'h02;
  localparam logic [7:0] HDR_N    = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PAYLOAD   = 3'd1,
    ST_CHECK     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_e;

  function automatic data_type_e hdr_to_type(input logic [7:0] hdr);
    data_type_e t;
    case (hdr)
      HDR_DATA: t = DT_DATA;
      HDR_E:    t = DT_E;
      HDR_N:    t = DT_N;
      default:  t = DT_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rsa_input_loader.sv
// rsa_input_loader: assembles byte frames (header + WORD_W/8 payload bytes,
// MSB first) into an operand word and issues it to the exponentiation
// controller with a one-cycle data_type command.
// Optional feature macro: RSA_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (header ^ payload bytes) checked before the word is issued.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   rx_valid/data : byte offered by the source
//   rx_ready      : loader accepts a byte (IDLE, PAYLOAD, CHECK)
//   data_type     : command code, non-zero only in the ISSUE cycle
//   word_out      : assembled operand, held until the next ISSUE
//   core_done     : completion pulse from the controller (DATA frames)
//   frame_error   : one-cycle pulse on bad header or checksum mismatch
module rsa_input_loader
  import rsa_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [2:0]        data_type,
  output logic [WORD_W-1:0] word_out,
  input  logic              core_done,
  output logic              frame_error
);

  localparam int unsigned NBYTES = WORD_W / 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  state_e            state_q, state_d;
  data_type_e        type_q, type_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_d;
  logic              accept;
`ifdef RSA_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  // rx_ready is a registered decode of the state, so it matches state_q
  assign accept = rx_valid & rx_ready;

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      type_q      <= DT_NONE;
      shift_q     <= '0;
      cnt_q       <= '0;
      rx_ready    <= 1'b1;
      data_type   <= 3'd0;
      word_out    <= '0;
      frame_error <= 1'b0;
`ifdef RSA_LOADER_CHECKSUM_EN
      chk_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rx_ready    <= (state_d == ST_IDLE) || (state_d == ST_PAYLOAD) ||
                     (state_d == ST_CHECK);
      data_type   <= (state_d == ST_ISSUE) ? type_d : DT_NONE;
      frame_error <= err_d;
      // shift_d already holds the final payload byte on the PAYLOAD->ISSUE edge
      if (state_d == ST_ISSUE && state_q != ST_ISSUE) begin
        word_out <= shift_d;
      end
`ifdef RSA_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef RSA_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hdr_to_type(rx_data) != DT_NONE) begin
            type_d  = hdr_to_type(rx_data);
            cnt_d   = '0;
            state_d = ST_PAYLOAD;
`ifdef RSA_LOADER_CHECKSUM_EN
            chk_d   = rx_data;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (accept) begin
          shift_d = (shift_q << 8) | WORD_W'(rx_data);
`ifdef RSA_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ rx_data;
`endif
          // Counter stops at NBYTES-1 so it never wraps inside a frame
          if (cnt_q == CNT_W'(NBYTES - 1)) begin
`ifdef RSA_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_ISSUE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_CHECK: begin
`ifdef RSA_LOADER_CHECKSUM_EN
        if (accept) begin
          if (rx_data == chk_q) begin
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_ISSUE: begin
        state_d = (type_q == DT_DATA) ? ST_WAIT_DONE : ST_HOLD;
      end

      // One extra stable cycle for the controller's E/N update strobe
      ST_HOLD: begin
        state_d = ST_IDLE;
      end

      ST_WAIT_DONE: begin
        if (core_done) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rsa_input_loader.sv
// tb_rsa_input_loader: directed self-checking bench for rsa_input_loader
// (WORD_W=32). Handles both builds of RSA_LOADER_CHECKSUM_EN.
module tb_rsa_input_loader;

  localparam int unsigned WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic [2:0]        data_type;
  logic [WORD_W-1:0] word_out;
  logic              core_done = 1'b0;
  logic              frame_error;

  int n_cmp = 0;
  int n_mis = 0;
  int dt_pulses = 0;
  int fe_pulses = 0;

  rsa_input_loader #(.WORD_W(WORD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .data_type   (data_type),
    .word_out    (word_out),
    .core_done   (core_done),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (data_type != 3'd0) dt_pulses++;
    if (frame_error) fe_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and return #1 after the edge on which it transferred
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!rx_ready) check("send_timeout", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] w, input int gap);
    logic [7:0] b;
    logic [7:0] chk;
    chk = hdr;
    send_byte(hdr);
    for (int i = 3; i >= 0; i--) begin
      b = w[i*8 +: 8];
      chk = chk ^ b;
      send_byte(b);
      if (gap > 0 && i > 0) repeat (gap) tick();
    end
`ifdef RSA_LOADER_CHECKSUM_EN
    send_byte(chk);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int f0;
    int hi_cnt;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(rx_ready), 32'd1);
    check("rst_type", 32'(data_type), 32'd0);
    check("rst_word", word_out, 32'h0);
    check("rst_err", 32'(frame_error), 32'd0);
    rst = 1'b0;
    tick();

    // core_done in IDLE is ignored
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    check("idle_done_ready", 32'(rx_ready), 32'd1);
    check("idle_done_type", 32'(data_type), 32'd0);

    // E frame: ISSUE, HOLD, then IDLE
    send_frame(8'h02, 32'h00010001, 0);
    check("e_type", 32'(data_type), 32'd2);
    check("e_word", word_out, 32'h00010001);
    check("e_ready_issue", 32'(rx_ready), 32'd0);
    tick();
    check("e_type_hold", 32'(data_type), 32'd0);
    check("e_ready_hold", 32'(rx_ready), 32'd0);
    check("e_word_hold", word_out, 32'h00010001);
    tick();
    check("e_ready_idle", 32'(rx_ready), 32'd1);

    // DATA frame waits for core_done
    p0 = dt_pulses;
    send_frame(8'h01, 32'hDEADBEEF, 0);
    check("data_type", 32'(data_type), 32'd1);
    check("data_word", word_out, 32'hDEADBEEF);
    hi_cnt = 0;
    repeat (20) begin
      tick();
      if (rx_ready) hi_cnt++;
    end
    check("data_wait_ready_high", 32'(hi_cnt), 32'd0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("data_ready_after_done", 32'(rx_ready), 32'd1);
    check("data_one_pulse", 32'(dt_pulses - p0), 32'd1);
    check("data_word_held", word_out, 32'hDEADBEEF);

    // Invalid header, then a normal N frame
    f0 = fe_pulses;
    send_byte(8'h07);
    check("bad_hdr_err", 32'(frame_error), 32'd1);
    check("bad_hdr_ready", 32'(rx_ready), 32'd1);
    tick();
    check("bad_hdr_err_clear", 32'(frame_error), 32'd0);
    check("bad_hdr_one_pulse", 32'(fe_pulses - f0), 32'd1);
    check("bad_hdr_word", word_out, 32'hDEADBEEF);
    send_frame(8'h03, 32'hCAFEF00D, 0);
    check("n_type", 32'(data_type), 32'd3);
    check("n_word", word_out, 32'hCAFEF00D);
    tick();
    tick();

    // Reset mid-frame discards the partial frame
    p0 = dt_pulses;
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(rx_ready), 32'd1);
    check("midrst_type", 32'(data_type), 32'd0);
    check("midrst_word", word_out, 32'h0);
    check("midrst_err", 32'(frame_error), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("midrst_no_pulse", 32'(dt_pulses - p0), 32'd0);
    send_frame(8'h02, 32'h0000ABCD, 0);
    check("post_rst_type", 32'(data_type), 32'd2);
    check("post_rst_word", word_out, 32'h0000ABCD);
    tick();
    tick();

    // Stalled payload with 5-cycle gaps
    f0 = fe_pulses;
    send_frame(8'h02, 32'h89ABCDEF, 5);
    check("gap_type", 32'(data_type), 32'd2);
    check("gap_word", word_out, 32'h89ABCDEF);
    check("gap_no_err", 32'(fe_pulses - f0), 32'd0);
    tick();
    tick();

`ifdef RSA_LOADER_CHECKSUM_EN
    // Good and bad checksum
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h47);
    check("chk_ok_type", 32'(data_type), 32'd3);
    check("chk_ok_word", word_out, 32'h11223344);
    tick();
    tick();
    send_byte(8'h03);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h00);
    check("chk_bad_err", 32'(frame_error), 32'd1);
    check("chk_bad_type", 32'(data_type), 32'd0);
    check("chk_bad_word", word_out, 32'h11223344);
    check("chk_bad_ready", 32'(rx_ready), 32'd1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
